// File: rtl/serial_byte_packer.sv
// Serial-to-byte packer feeding a first-word fall-through byte FIFO with packet framing.
// Define PACKER_MSB_FIRST_EN to pack the first sampled bit into byte bit 7 (default: bit 0).
module serial_byte_packer #(
   parameter int FIFO_DEPTH = 16,
   parameter int PKT_BYTES  = 512
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          data_in,
   input  logic                          bit_valid,
   input  logic                          flush,
   output logic [7:0]                    byte_out,
   output logic                          byte_valid,
   input  logic                          byte_ready,
   output logic                          pkt_last,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;

   logic [7:0]    sr;
   logic [2:0]    cnt;
   logic [2:0]    bit_pos;
   logic [7:0]    sr_ins;
   logic          byte_done;
   logic          flush_part;
   logic          emit;
   logic          vld_p1;
   logic [7:0]    byte_p1;
   logic          last_p1;
   logic [8:0]    mem [FIFO_DEPTH];
   logic [AW:0]   wp;
   logic [AW:0]   rp;
   logic [AW:0]   level;
   logic [8:0]    head;
   logic [PW-1:0] pcnt;
   logic          full;
   logic          hs;
   logic          wr_ok;

   always_comb begin
`ifdef PACKER_MSB_FIRST_EN
      bit_pos = 3'd7 - cnt;
`else
      bit_pos = cnt;
`endif
      sr_ins = sr;
      if (bit_valid) sr_ins[bit_pos] = data_in;
   end

   // Unfilled positions of sr are always zero, so a flushed partial byte is already zero-filled.
   assign byte_done  = bit_valid && (cnt == 3'd7);
   assign flush_part = flush && !byte_done && (bit_valid || (cnt != 3'd0));
   assign emit       = byte_done || flush_part;

   assign level      = wp - rp;
   assign full       = (level == (AW+1)'(FIFO_DEPTH));
   assign head       = mem[rp[AW-1:0]];
   assign byte_valid = (level != '0);
   assign byte_out   = byte_valid ? head[7:0] : 8'h00;
   assign pkt_last   = byte_valid && (head[8] || (pcnt == PW'(PKT_BYTES - 1)));
   assign fifo_level = level;
   assign hs         = byte_valid && byte_ready;
   assign wr_ok      = vld_p1 && (!full || hs);

   // Stage p0 -> p1: packer and staging register control
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr       <= '0;
         cnt      <= '0;
         vld_p1   <= 1'b0;
         wp       <= '0;
         rp       <= '0;
         pcnt     <= '0;
         overflow <= 1'b0;
      end else begin
         if (emit) begin
            sr  <= '0;
            cnt <= '0;
         end else if (bit_valid) begin
            sr  <= sr_ins;
            cnt <= cnt + 3'd1;
         end
         vld_p1 <= emit;
         if (wr_ok) wp <= wp + 1'b1;
         else if (vld_p1) overflow <= 1'b1;
         if (hs) begin
            rp   <= rp + 1'b1;
            pcnt <= pkt_last ? '0 : pcnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      byte_p1 <= sr_ins;
      last_p1 <= flush;
   end

   // Stage p1 -> FIFO
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wp[AW-1:0]] <= {last_p1, byte_p1};
   end

endmodule

// File: tb/tb_serial_byte_packer.sv
// Directed bench for serial_byte_packer (FIFO_DEPTH=16, PKT_BYTES=4); honours PACKER_MSB_FIRST_EN.
module tb_serial_byte_packer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       data_in = 1'b0;
   logic       bit_valid = 1'b0;
   logic       flush = 1'b0;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic       byte_ready = 1'b0;
   logic       pkt_last;
   logic [4:0] fifo_level;
   logic       overflow;

   int compared = 0;
   int mismatched = 0;
   logic [8:0] q[$];

   serial_byte_packer #(.FIFO_DEPTH(16), .PKT_BYTES(4)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .bit_valid(bit_valid), .flush(flush),
      .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .pkt_last(pkt_last), .fifo_level(fifo_level), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Inputs change 1 time unit after posedge, so at negedge they are settled.
   always @(negedge clk)
      if (!rst && byte_valid && byte_ready) q.push_back({pkt_last, byte_out});

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic bv, input logic b, input logic fl);
      @(posedge clk);
      #1;
      bit_valid = bv;
      data_in   = b;
      flush     = fl;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 1'b0);
   endtask

   function automatic logic bit_of(input logic [7:0] v, input int i);
`ifdef PACKER_MSB_FIRST_EN
      return v[7-i];
`else
      return v[i];
`endif
   endfunction

   task automatic send_byte(input logic [7:0] v, input logic fl);
      for (int i = 0; i < 8; i++) step(1'b1, bit_of(v, i), fl && (i == 7));
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      bit_valid = 1'b0;
      flush = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
   endtask

   initial begin
      logic [7:0] exp_034;
      logic [7:0] exp_035;
      logic [7:0] seq_034;
      int         hi;
      int         first_c;
      logic [7:0] seen_b;
      logic       seen_l;
`ifdef PACKER_MSB_FIRST_EN
      exp_034 = 8'hB0;
      exp_035 = 8'hA0;
`else
      exp_034 = 8'h0D;
      exp_035 = 8'h05;
`endif
      seq_034 = 8'b0000_1101;

      // Reset state
      @(negedge clk);
      check("rst_byte_valid", byte_valid, 0);
      check("rst_pkt_last", pkt_last, 0);
      check("rst_fifo_level", fifo_level, 0);
      check("rst_byte_out", byte_out, 0);
      check("rst_overflow", overflow, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      byte_ready = 1'b1;

      // Bits 1,0,1,1,0,0,0,0: one-cycle valid pulse one edge after the 8th bit
      for (int i = 0; i < 8; i++) step(1'b1, seq_034[i], 1'b0);
      hi = 0; first_c = -1; seen_b = 8'h00; seen_l = 1'b1;
      for (int c = 0; c < 6; c++) begin
         step(1'b0, 1'b0, 1'b0);
         @(negedge clk);
         if (byte_valid) begin
            if (hi == 0) begin
               first_c = c; seen_b = byte_out; seen_l = pkt_last;
            end
            hi++;
         end
      end
      check("b034_valid_cycles", hi, 1);
      check("b034_latency", first_c, 1);
      check("b034_byte", seen_b, exp_034);
      check("b034_last", seen_l, 0);

      // Flush with empty bit counter does nothing
      do_reset();
      step(1'b0, 1'b0, 1'b1);
      idle(4);
      check("flush_empty_count", q.size(), 0);
      check("flush_empty_level", fifo_level, 0);

      // Bits 1,0,1 with flush on the 3rd bit, then packet counter restarts
      do_reset();
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      idle(5);
      check("flush_part_count", q.size(), 1);
      if (q.size() >= 1) check("flush_part_entry", q[0], {1'b1, exp_035});
      for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i), 1'b0);
      idle(5);
      check("after_flush_count", q.size(), 5);
      if (q.size() == 5)
         for (int i = 1; i < 5; i++)
            check($sformatf("after_flush_%0d", i), q[i], {(i == 4), 8'h10 + 8'(i)});

      // Flush together with the 8th bit: one byte, marked last
      do_reset();
      send_byte(8'h5A, 1'b1);
      idle(5);
      check("flush_full_count", q.size(), 1);
      if (q.size() >= 1) check("flush_full_entry", q[0], {1'b1, 8'h5A});

      // PKT_BYTES=4: nine bytes, last on 4th and 8th
      do_reset();
      for (int i = 0; i < 9; i++) send_byte(8'h21 + 8'(i), 1'b0);
      idle(5);
      check("pkt_count", q.size(), 9);
      if (q.size() == 9)
         for (int i = 0; i < 9; i++)
            check($sformatf("pkt_byte_%0d", i), q[i], {(i == 3 || i == 7), 8'h21 + 8'(i)});

      // Overflow: 17 bytes into a 16-deep FIFO with no reads
      do_reset();
      byte_ready = 1'b0;
      for (int i = 0; i < 17; i++) send_byte(8'h40 + 8'(i), 1'b0);
      idle(3);
      @(negedge clk);
      check("ovf_level", fifo_level, 16);
      check("ovf_flag", overflow, 1);
      check("ovf_head", byte_out, 8'h40);
      @(posedge clk);
      #1;
      byte_ready = 1'b1;
      idle(20);
      check("drain_count", q.size(), 16);
      if (q.size() == 16)
         for (int i = 0; i < 16; i++)
            check($sformatf("drain_%0d", i), q[i][7:0], 8'h40 + 8'(i));
      @(negedge clk);
      check("drain_level", fifo_level, 0);
      check("drain_ovf_sticky", overflow, 1);

      // Reset mid-byte with buffered data
      do_reset();
      byte_ready = 1'b0;
      for (int i = 0; i < 3; i++) send_byte(8'h61 + 8'(i), 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      bit_valid = 1'b0;
      @(negedge clk);
      check("midrst_valid", byte_valid, 0);
      check("midrst_level", fifo_level, 0);
      check("midrst_byte_out", byte_out, 0);
      check("midrst_last", pkt_last, 0);
      check("midrst_ovf", overflow, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      byte_ready = 1'b1;
      q.delete();
      bit_valid = 1'b1;
      data_in = bit_of(8'hC3, 0);
      for (int i = 1; i < 8; i++) step(1'b1, bit_of(8'hC3, i), 1'b0);
      idle(5);
      check("postrst_count", q.size(), 1);
      if (q.size() >= 1) check("postrst_entry", q[0], {1'b0, 8'hC3});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
